dcm_multi: RTL
==============

Name: dcm_multi

Overview:
- Parametrised multi-channel successor of the single programmable clock/tick divider.
- Each of NUM_CH independent channels divides the system clock by a programmable power-of-two rate.
- Each channel drives a square-wave enable clock and a one-cycle tick. Channels have per-channel enable, selection readback, and an optional glitch-free deferred update mode.
- Sits between the board clock and the downstream counters/FSMs that need slow, selectable timebases.

Parameters:
- NUM_CH, 2, number of independent divider channels
- CNT_W, 32, width of each half-period counter
- SEL_W, 3, width of each channel's rate selector
- BASE_HALF, 5_000_000, half-period in clocks for selector 0 (10 Hz at 100 MHz)
- DEFAULT_SEL, 0, selector loaded at reset
- SYNC_UPDATE, 0, 0 = update applies immediately; 1 = update deferred to next falling edge of clk_out

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- update  in  NUM_CH  per-channel load strobe for the prog_in slice
- enable  in  NUM_CH  per-channel run enable
- prog_in  in  NUM_CH*SEL_W  rate selectors; channel i uses bits [i*SEL_W +: SEL_W]
- clk_out  out  NUM_CH  per-channel square wave, 50% duty
- tick  out  NUM_CH  one-cycle pulse coincident with each clk_out rising edge
- prog_out  out  NUM_CH*SEL_W  selector currently in effect per channel
- pending  out  NUM_CH  deferred update waiting (always 0 when SYNC_UPDATE=0)

Behaviour:
- Half-period: HALF(sel) = BASE_HALF << sel.
  - Computed at CNT_W bits.
  - Elaboration must fail (generate-time check) if BASE_HALF << (2^SEL_W - 1) exceeds 2^CNT_W - 1.
  - BASE_HALF >= 1.
- Reset (reset=0 at a clock edge), all channels:
  - counter=0, clk_out=0, tick=0
  - sel=DEFAULT_SEL, prog_out=DEFAULT_SEL
  - pending=0, pending selector=0
- Run (enable=1), counter counts 0..HALF(sel)-1.
  - Terminal cycle (counter==HALF-1): counter<=0 and clk_out toggles.
  - tick<=1 on the same edge where clk_out goes 0->1; otherwise tick<=0.
  - Output period = 2*HALF clocks. First rising edge after reset or restart comes HALF clocks after enable is seen high.
- Hold (enable=0): counter and clk_out frozen; tick=0. Resuming continues from the frozen count.
- Immediate update (SYNC_UPDATE=0, update[i]=1):
  - sel<=prog_in slice, counter<=0, clk_out<=0, tick<=0. Applies regardless of enable.
  - Update overrides a coincident terminal event.
  - prog_out reflects the new value on the next cycle.
- Deferred update (SYNC_UPDATE=1, update[i]=1):
  - Slice captured into the pending register; pending[i]<=1.
  - Applied (sel<=pending value, pending<=0, counter<=0) on the terminal cycle where clk_out toggles 1->0. clk_out still goes low there.
  - If clk_out==0 and enable==0, applied on the cycle after capture.
  - A second update while pending overwrites the pending value, last writer wins.
  - Update coincident with the 1->0 terminal cycle: the new prog_in value is applied directly at that edge, and pending stays 0.
  - No runt pulses: every high phase lasts exactly HALF(old sel).
- Channels are fully independent. Simultaneous updates on several channels are all honoured in the same cycle.
- Reset mid-operation (including with pending=1): pending is discarded and all state returns to reset values on that edge.
- tick is never high while enable=0 or during reset. At most one tick per 2*HALF clocks.

Test Plan:
- BASE_HALF=2, NUM_CH=2, release reset, enable=11, sel=0 -> clk_out[0] rises at clock 2, period 4 clocks; tick[0] is 1 for exactly 1 cycle on each rise; prog_out=0.
- Channel 1 update with prog_in slice=3 (immediate mode) -> clk_out[1] drops to 0 next cycle, then period 32 clocks (HALF=16); prog_out[5:3]=3; channel 0 waveform undisturbed.
- enable[0]=0 for 5 cycles mid-high-phase -> clk_out[0] held high, no tick; resumes and completes the remaining count exactly.
- SYNC_UPDATE=1, update to sel=1 while clk_out high at counter=0 -> pending=1 and the high phase still lasts 2 clocks; at the 1->0 edge pending clears and the next period is 8 clocks. A second update (sel=2) before that edge gives period 16.
- Update asserted on the same cycle as a terminal event, in both modes -> immediate mode: counter=0, clk_out=0; sync mode falling edge: new sel is taken with no pending cycle.
- reset=0 asserted while pending=1 and clk_out high -> next cycle all outputs are 0, prog_out=DEFAULT_SEL, and nothing is applied later.

Source files
------------

// File: rtl/dcm_multi.sv
// Multi-channel programmable power-of-two clock/tick divider.
// Each channel emits a 50% square wave and a one-cycle tick on every rising edge.
module dcm_multi #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 32,
  parameter int SEL_W       = 3,
  parameter int BASE_HALF   = 5_000_000,
  parameter int DEFAULT_SEL = 0,
  parameter int SYNC_UPDATE = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       update,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*SEL_W-1:0] prog_in,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH*SEL_W-1:0] prog_out,
  output logic [NUM_CH-1:0]       pending
);

  localparam int MAX_SH = (1 << SEL_W) - 1;
  localparam int WIDE_W = CNT_W + MAX_SH + 1;
  localparam logic [WIDE_W-1:0] MAX_HALF = WIDE_W'(BASE_HALF) << MAX_SH;
  localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_SEL);

  // The slowest rate must still fit in the half-period counter.
  if (BASE_HALF < 1) begin : g_bad_base
    $error("dcm_multi: BASE_HALF must be at least 1");
  end
  if (MAX_HALF[WIDE_W-1:CNT_W] != '0) begin : g_bad_range
    $error("dcm_multi: BASE_HALF << (2**SEL_W-1) does not fit in CNT_W bits");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] pend_sel;
    logic [SEL_W-1:0] new_sel;
    logic             clk_r;
    logic             tick_r;
    logic             pend_r;
    logic             term;
    logic             fall;

    assign new_sel = prog_in[i*SEL_W +: SEL_W];
    assign half    = CNT_W'(BASE_HALF) << sel;
    assign term    = enable[i] && (cnt == half - CNT_W'(1));
    assign fall    = term && clk_r;

    always_ff @(posedge clock) begin
      if (!reset) begin
        cnt      <= '0;
        clk_r    <= 1'b0;
        tick_r   <= 1'b0;
        sel      <= DEF_SEL;
        pend_sel <= '0;
        pend_r   <= 1'b0;
      end else begin
        tick_r <= 1'b0;
        // Immediate mode, or a deferred update landing exactly on the falling edge.
        if (update[i] && (SYNC_UPDATE == 0 || fall)) begin
          sel    <= new_sel;
          cnt    <= '0;
          clk_r  <= 1'b0;
          pend_r <= 1'b0;
        end else begin
          if (update[i]) begin
            pend_r   <= 1'b1;
            pend_sel <= new_sel;
          end
          // A parked low channel can take the new rate without cutting a pulse.
          if (!update[i] && pend_r && (fall || (!clk_r && !enable[i]))) begin
            sel    <= pend_sel;
            pend_r <= 1'b0;
            cnt    <= '0;
            clk_r  <= 1'b0;
          end else if (term) begin
            cnt    <= '0;
            clk_r  <= ~clk_r;
            tick_r <= ~clk_r;
          end else if (enable[i]) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end

    assign clk_out[i]                  = clk_r;
    assign tick[i]                     = tick_r;
    assign pending[i]                  = pend_r;
    assign prog_out[i*SEL_W +: SEL_W]  = sel;
  end

endmodule
